// File: rtl/sobel_pkg.sv
// Shared types for the Sobel frame sequencer.
// Holds the FSM encoding, position width and the tag word layout.
package sobel_pkg;

  localparam int POS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // valid must stay the MSB: the delay line keys off it
  typedef struct packed {
    logic             valid;
    logic             border;
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/sobel_frame_seq_if.sv
// Bus bundle between the frame sequencer and its neighbours.
// master: sequencer side (start/stall in, read + tag outputs out).
interface sobel_frame_seq_if #(
  parameter int ADDR_W = 16
);
  logic              start_i;
  logic              stall_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              pix_valid_o;
  logic              border_o;
  logic [15:0]       out_col_o;
  logic [15:0]       out_row_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       frame_cnt_o;

  modport master (
    input  start_i, stall_i,
    output rd_en_o, rd_addr_o,
    output pix_valid_o, border_o,
    output out_col_o, out_row_o,
    output busy_o, done_o, frame_cnt_o
  );

  modport slave (
    output start_i, stall_i,
    input  rd_en_o, rd_addr_o,
    input  pix_valid_o, border_o,
    input  out_col_o, out_row_o,
    input  busy_o, done_o, frame_cnt_o
  );
endinterface

// File: rtl/sobel_tag_delay.sv
// DEPTH-stage tag shift register; MSB of each word is its valid bit.
// Ports: clk_i, rst_i (async high), d_i, q_o (last stage), pend_o.
module sobel_tag_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];

  // an empty slot keeps its old payload so the output
  // position holds between valid pixels
  always_comb begin
    stg_d[0] = d_i[WIDTH-1] ? d_i
             : {1'b0, stg_q[0][WIDTH-2:0]};
    for (int i = 1; i < DEPTH; i++) begin
      stg_d[i] = stg_q[i-1][WIDTH-1] ? stg_q[i-1]
               : {1'b0, stg_q[i][WIDTH-2:0]};
    end
  end

  // pending excludes the output stage: that entry is
  // already being presented this cycle
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pend_o = pend_o | stg_q[i][WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_seq.sv
// Raster frame sequencer: issues one read per pixel, delays tags.
// Ports: sys_clk_i, sys_rst_i (async high), bus (master modport).
module sobel_frame_seq
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input logic sys_clk_i,
  input logic sys_rst_i,
  sobel_frame_seq_if.master bus
);

  localparam logic [POS_W-1:0] COL_MAX = POS_W'(IMG_W - 1);
  localparam logic [POS_W-1:0] ROW_MAX = POS_W'(IMG_H - 1);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       frame_q, frame_d;
  logic              rd_en;
  logic              pend;
  tag_t              tag_in;
  tag_t              tag_out;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        if (!bus.stall_i) begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_MAX) state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!pend) state_d = DONE;
      end
      DONE: begin
        frame_d = frame_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_in        = '0;
    tag_in.valid  = rd_en;
    tag_in.border = (col_q == '0) || (col_q == COL_MAX)
                 || (row_q == '0) || (row_q == ROW_MAX);
    tag_in.col    = col_q;
    tag_in.row    = row_q;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
    end
  end

  sobel_tag_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (TAG_W)
  ) u_dly (
    .clk_i  (sys_clk_i),
    .rst_i  (sys_rst_i),
    .d_i    (tag_in),
    .q_o    (tag_out),
    .pend_o (pend)
  );

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = addr_q;
  assign bus.pix_valid_o = tag_out.valid;
  assign bus.border_o    = tag_out.border;
  assign bus.out_col_o   = tag_out.col;
  assign bus.out_row_o   = tag_out.row;
  assign bus.busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done_o      = (state_q == DONE);
  assign bus.frame_cnt_o = frame_q;

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Scoreboard bench for sobel_frame_seq.
// DUT a: 4x3, RD_LAT=2; DUT b: 3x3, RD_LAT=1.
module tb_sobel_frame_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_frame_seq_if #(.ADDR_W(16)) a ();
  sobel_frame_seq_if #(.ADDR_W(16)) b ();

  sobel_frame_seq #(
    .IMG_W(4), .IMG_H(3), .ADDR_W(16), .RD_LAT(2)
  ) dut_a (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (a.master)
  );

  sobel_frame_seq #(
    .IMG_W(3), .IMG_H(3), .ADDR_W(16), .RD_LAT(1)
  ) dut_b (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (b.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int st_lo = 100;
  int st_hi = -1;

  int qa_addr[$], qa_pix[$], qa_lat[$];
  int qb_addr[$], qb_pix[$], qb_lat[$];

  int a_nrd, a_frd, a_lrd, a_rd2, a_fv, a_lv, a_nv;
  int a_nb0, a_ndone, a_done1, a_donel;
  int b_nrd, b_frd, b_fv, b_lv, b_nv, b_nb0;
  int b_ndone, b_done1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int enc(int c, int r, int bd);
    return (bd << 16) | (r << 8) | c;
  endfunction

  task automatic push_frame(input bit isb,
                            input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int bd;
        bd = (c == 0 || c == w - 1 ||
              r == 0 || r == h - 1) ? 1 : 0;
        if (isb) begin
          qb_addr.push_back(r * w + c);
          qb_pix.push_back(enc(c, r, bd));
        end else begin
          qa_addr.push_back(r * w + c);
          qa_pix.push_back(enc(c, r, bd));
        end
      end
    end
  endtask

  task automatic clr_mon();
    a_nrd = 0; a_frd = -1; a_lrd = -1; a_rd2 = -1;
    a_fv = -1; a_lv = -1; a_nv = 0; a_nb0 = 0;
    a_ndone = 0; a_done1 = -1; a_donel = -1;
    b_nrd = 0; b_frd = -1; b_fv = -1; b_lv = -1;
    b_nv = 0; b_nb0 = 0; b_ndone = 0; b_done1 = -1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a.rd_en_o) begin
        if (qa_addr.size() == 0)
          chk("a_extra_rd", 1, 0);
        else
          chk("a_addr", a.rd_addr_o, qa_addr.pop_front());
        qa_lat.push_back(cyc);
        if (a_nrd == 0) a_frd = cyc - t0;
        if (a_ndone == 1 && a_rd2 < 0) a_rd2 = cyc - t0;
        a_lrd = cyc - t0;
        a_nrd++;
      end
      if (a.pix_valid_o) begin
        if (qa_pix.size() == 0 || qa_lat.size() == 0) begin
          chk("a_extra_pix", 1, 0);
        end else begin
          chk("a_pix",
              (int'(a.border_o) << 16) |
              (int'(a.out_row_o) << 8) |
              int'(a.out_col_o),
              qa_pix.pop_front());
          chk("a_lat", cyc - qa_lat.pop_front(), 2);
        end
        if (a_nv == 0) a_fv = cyc - t0;
        a_lv = cyc - t0;
        a_nv++;
        if (!a.border_o) a_nb0++;
      end
      if (a.done_o) begin
        a_ndone++;
        if (a_ndone == 1) a_done1 = cyc - t0;
        a_donel = cyc - t0;
      end
      if (b.rd_en_o) begin
        if (qb_addr.size() == 0)
          chk("b_extra_rd", 1, 0);
        else
          chk("b_addr", b.rd_addr_o, qb_addr.pop_front());
        qb_lat.push_back(cyc);
        if (b_nrd == 0) b_frd = cyc - t0;
        b_nrd++;
      end
      if (b.pix_valid_o) begin
        if (qb_pix.size() == 0 || qb_lat.size() == 0) begin
          chk("b_extra_pix", 1, 0);
        end else begin
          chk("b_pix",
              (int'(b.border_o) << 16) |
              (int'(b.out_row_o) << 8) |
              int'(b.out_col_o),
              qb_pix.pop_front());
          chk("b_lat", cyc - qb_lat.pop_front(), 1);
        end
        if (b_nv == 0) b_fv = cyc - t0;
        b_lv = cyc - t0;
        b_nv++;
        if (!b.border_o) b_nb0++;
      end
      if (b.done_o) begin
        b_ndone++;
        if (b_ndone == 1) b_done1 = cyc - t0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    a.stall_i = (cyc - t0 >= st_lo) && (cyc - t0 <= st_hi);
  endtask

  task automatic start_frame(input bit isb, input bit hold);
    t0 = cyc;
    if (isb) b.start_i = 1'b1;
    else     a.start_i = 1'b1;
    if (!hold) begin
      tick();
      a.start_i = 1'b0;
      b.start_i = 1'b0;
    end
  endtask

  task automatic wait_done(input bit isb, input int target,
                           input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      tick();
      if ((isb ? b_ndone : a_ndone) >= target) break;
    end
    chk(isb ? "b_timeout" : "a_timeout",
        n < budget, 1);
  endtask

  task automatic chk_zero_a(input string pfx);
    chk({pfx, "_ctl"},
        {a.rd_en_o, a.pix_valid_o, a.border_o,
         a.busy_o, a.done_o}, 0);
    chk({pfx, "_addr"}, a.rd_addr_o, 0);
    chk({pfx, "_pos"}, a.out_col_o | a.out_row_o, 0);
    chk({pfx, "_fcnt"}, a.frame_cnt_o, 0);
  endtask

  initial begin
    a.start_i = 1'b0;
    a.stall_i = 1'b0;
    b.start_i = 1'b0;
    b.stall_i = 1'b0;
    clr_mon();
    #3;
    chk_zero_a("rst");
    chk("rst_b_fcnt", b.frame_cnt_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic frame
    clr_mon();
    push_frame(0, 4, 3);
    start_frame(0, 0);
    chk("basic_busy", a.busy_o, 1);
    wait_done(0, 1, 40);
    chk("basic_frd", a_frd, 1);
    chk("basic_lrd", a_lrd, 12);
    chk("basic_nrd", a_nrd, 12);
    chk("basic_fv", a_fv, 3);
    chk("basic_lv", a_lv, 14);
    chk("basic_done", a_done1, 15);
    chk("basic_nb0", a_nb0, 2);
    chk("basic_fcnt", a.frame_cnt_o, 1);
    chk("basic_idle", a.busy_o, 0);
    tick();

    // stall during cycles 4..6
    clr_mon();
    push_frame(0, 4, 3);
    st_lo = 4;
    st_hi = 6;
    start_frame(0, 0);
    wait_done(0, 1, 40);
    st_lo = 100;
    st_hi = -1;
    chk("stall_nrd", a_nrd, 12);
    chk("stall_lrd", a_lrd, 15);
    chk("stall_lv", a_lv, 17);
    chk("stall_done", a_done1, 18);
    chk("stall_fcnt", a.frame_cnt_o, 2);
    tick();

    // start held high across two frames
    clr_mon();
    push_frame(0, 4, 3);
    push_frame(0, 4, 3);
    start_frame(0, 1);
    wait_done(0, 2, 60);
    a.start_i = 1'b0;
    tick();
    tick();
    tick();
    chk("hold_done1", a_done1, 15);
    chk("hold_rd2", a_rd2, 17);
    chk("hold_done2", a_donel, 31);
    chk("hold_nrd", a_nrd, 24);
    chk("hold_ndone", a_ndone, 2);
    chk("hold_fcnt", a.frame_cnt_o, 4);
    chk("hold_q", qa_addr.size(), 0);

    // async reset mid-frame
    clr_mon();
    push_frame(0, 4, 3);
    start_frame(0, 0);
    while (cyc - t0 < 7) tick();
    #1;
    rst = 1'b1;
    #1;
    chk_zero_a("mid");
    tick();
    tick();
    rst = 1'b0;
    qa_addr.delete();
    qa_pix.delete();
    qa_lat.delete();
    tick();
    tick();
    chk("mid_ndone", a_ndone, 0);
    clr_mon();
    push_frame(0, 4, 3);
    start_frame(0, 0);
    wait_done(0, 1, 40);
    chk("rerun_nrd", a_nrd, 12);
    chk("rerun_frd", a_frd, 1);
    chk("rerun_done", a_done1, 15);
    chk("rerun_fcnt", a.frame_cnt_o, 1);
    tick();

    // 3x3 frame, RD_LAT=1
    clr_mon();
    push_frame(1, 3, 3);
    start_frame(1, 0);
    wait_done(1, 1, 40);
    chk("b_nrd", b_nrd, 9);
    chk("b_frd", b_frd, 1);
    chk("b_fv", b_fv, 2);
    chk("b_lv", b_lv, 10);
    chk("b_done", b_done1, 11);
    chk("b_nb0", b_nb0, 1);
    chk("b_nv", b_nv, 9);
    chk("b_fcnt", b.frame_cnt_o, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
